// File: rtl/temp_mmss_bcd_pkg.sv
// temp_mmss_bcd_pkg
// Shared definitions for the BCD mm:ss countdown timer:
//   - state_e      : FSM encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   - UNITS_MAX    : largest value of any units digit (and of minutes tens)
//   - SEC_TENS_MAX : largest value of the seconds tens digit
//   - preset_ok()  : checks a {min, sec} BCD preset for legal digits
package temp_mmss_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] UNITS_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic preset_ok(input logic [7:0] m, input logic [7:0] s);
    return (m[7:4] <= UNITS_MAX) && (m[3:0] <= UNITS_MAX) &&
           (s[7:4] <= SEC_TENS_MAX) && (s[3:0] <= UNITS_MAX);
  endfunction

endpackage

// File: rtl/temp_mmss_bcd_dig_dn.sv
// bcd_dig_dn
// One BCD digit down-counter. Digits are chained through borrow: a digit
// decrements when en is high, and wraps 0 -> MAX while raising borrow so
// the next more significant digit decrements in the same cycle.
// Ports:
//   clk     in  clock (rising edge)
//   rst_n   in  synchronous active-low reset, digit -> 0
//   en      in  decrement this cycle
//   ld      in  load d (wins over en)
//   d       in  load value
//   q       out current digit
//   borrow  out en & (q == 0): the wrap request for the next digit
module bcd_dig_dn #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? MAX : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 4'd0;
    else        q_q <= q_d;
  end

  assign q      = q_q;
  assign borrow = en && (q_q == 4'd0);

endmodule

// File: rtl/temp_mmss_bcd.sv
// temp_mmss_bcd
// BCD countdown timer mm:ss (00:00..99:59). A prescaler counts tick strobes
// in RUN and every TICKS_PER_SEC strobes decrements the value by one second.
// Ports:
//   mclk, reset (sync, active-low)
//   tick            enable strobe from the tick generator
//   load/start/pause/clear  one-cycle commands (priority clear>load>start>pause)
//   preset_min/sec  BCD preset captured by load
//   min_bcd/sec_bcd current value; running/done state flags
//   expired         one-cycle pulse on reaching 00:00 by decrement
//   load_err        one-cycle pulse when a load carries an illegal digit
// Interface semantics: tick is a pure enable strobe with no back-pressure;
// it is high for a single mclk cycle per period and is consumed on the edge
// where it is sampled, or dropped when the timer is not in RUN.
module temp_mmss_bcd
  import temp_mmss_bcd_pkg::*;
#(
  parameter int TICKS_PER_SEC = 500
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          expired_q, expired_d;
  logic          load_err_q, load_err_d;

  logic          dig_ld;
  logic [7:0]    ld_min, ld_sec;
  logic          any_cmd, sec_dec;
  logic          su_bw, st_bw, mu_bw, mt_bw;
  logic [3:0]    su_q, st_q, mu_q, mt_q;
  logic          is_one, nonzero;

  // Any command in the cycle discards a coincident tick.
  assign any_cmd = clear || load || start || pause;
  assign sec_dec = (state_q == ST_RUN) && tick && !any_cmd && (presc_q == PRESC_LAST);

  assign is_one  = ({mt_q, mu_q, st_q, su_q} == 16'h0001);
  assign nonzero = |{mt_q, mu_q, st_q, su_q};

  bcd_dig_dn #(.MAX(UNITS_MAX)) u_sec_u (
    .clk(mclk), .rst_n(reset), .en(sec_dec), .ld(dig_ld), .d(ld_sec[3:0]),
    .q(su_q), .borrow(su_bw));
  bcd_dig_dn #(.MAX(SEC_TENS_MAX)) u_sec_t (
    .clk(mclk), .rst_n(reset), .en(su_bw), .ld(dig_ld), .d(ld_sec[7:4]),
    .q(st_q), .borrow(st_bw));
  bcd_dig_dn #(.MAX(UNITS_MAX)) u_min_u (
    .clk(mclk), .rst_n(reset), .en(st_bw), .ld(dig_ld), .d(ld_min[3:0]),
    .q(mu_q), .borrow(mu_bw));
  bcd_dig_dn #(.MAX(UNITS_MAX)) u_min_t (
    .clk(mclk), .rst_n(reset), .en(mu_bw), .ld(dig_ld), .d(ld_min[7:4]),
    .q(mt_q), .borrow(mt_bw));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    expired_d  = 1'b0;
    load_err_d = 1'b0;
    dig_ld     = 1'b0;
    ld_min     = 8'h00;
    ld_sec     = 8'h00;

    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      dig_ld  = 1'b1;
    end else if (load) begin
      // Load is silently ignored in RUN, even with an illegal preset.
      if (state_q != ST_RUN) begin
        if (preset_ok(preset_min, preset_sec)) begin
          state_d = ST_IDLE;
          presc_d = '0;
          dig_ld  = 1'b1;
          ld_min  = preset_min;
          ld_sec  = preset_sec;
        end else begin
          load_err_d = 1'b1;
        end
      end
    end else if (start) begin
      if (nonzero && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
        state_d = ST_RUN;
        // Resuming from PAUSE keeps the partial second.
        if (state_q == ST_IDLE) presc_d = '0;
      end
    end else if (pause) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (state_q == ST_RUN && tick) begin
      if (sec_dec) begin
        presc_d = '0;
        // mt_bw would mean an underflow from 00:00, which RUN never holds;
        // treat it as expiry so the counter can never wrap to 99:59.
        if (is_one || mt_bw) begin
          state_d   = ST_DONE;
          expired_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  assign min_bcd  = {mt_q, mu_q};
  assign sec_bcd  = {st_q, su_q};
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign expired  = expired_q;
  assign load_err = load_err_q;

endmodule
